cpu_clk_ctrl: RTL and testbench
===============================

# cpu_clk_ctrl

Run/halt/single-step controller for the 8-bit CPU clock. It produces a one-cycle clock-enable (`cpu_ce`) for the CPU datapath at a programmable divide ratio of `clk`, and accepts RUN / HALT / STEP / CLEAR commands over a valid/ready handshake. It also counts issued CPU cycles and honours a halt request from the core (HLT instruction or breakpoint). The block sits between the debug/front-panel command source and every `cpu_ce`-gated register in the core.

## Interface
- `DIV_W`, 8: width of the divide ratio.
- `CNT_W`, 16: width of the CPU cycle counter.
- `STEP_W`, 8: width of the step count.

- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_op`  in  2  command: 0 RUN, 1 HALT, 2 STEP, 3 CLEAR.
- `cmd_div`  in  DIV_W  divide ratio, sampled on RUN/STEP accept; 0 is treated as 1.
- `cmd_steps`  in  STEP_W  number of CPU cycles for STEP; 0 is treated as 1.
- `halt_req`  in  1  level halt request from the core.
- `cpu_ce`  out  1  one-`clk`-wide CPU clock enable.
- `state`  out  2  current state: 0 HALT, 1 RUN, 2 STEP.
- `step_done`  out  1  one-cycle pulse when a STEP completes normally.
- `cycle_count`  out  CNT_W  number of `cpu_ce` pulses issued; wraps.

## Operation
- States: HALT (reset state), RUN, STEP.
- Registers: `div_q`, prescaler `pre` (0..`div_q`-1), `steps_left`, `cycle_count`.
- `cmd_ready = !halt_req && (state != STEP)`. STEP cannot be interrupted by a command; only `halt_req` or `reset` ends it early.
- Accepted RUN: load `div_q`, clear `pre`, next state RUN. Accepted RUN while already in RUN restarts the prescaler with the new ratio.
- Accepted STEP (only reachable from HALT or RUN): load `div_q`, `steps_left = max(cmd_steps,1)`, clear `pre`, next state STEP.
- Accepted HALT: next state HALT, `pre` cleared.
- Accepted CLEAR: `cycle_count` goes to 0; state, `pre` and `div_q` are unchanged.
- Prescaler in RUN/STEP: `pre` increments each cycle and wraps to 0 after reaching `div_q`-1. It is held at 0 in HALT.
- `cpu_ce = (state != HALT) && (pre == div_q-1) && !halt_req`. This is combinational from registered state.
- On each `cpu_ce`: `cycle_count` +1, wrapping at 2^CNT_W. In STEP, `steps_left` is decremented.
- STEP: the `cpu_ce` issued with `steps_left == 1` causes next state HALT, and `step_done = 1` for one cycle in that next cycle.
- `halt_req` high in RUN or STEP: no `cpu_ce`, next state HALT, `pre` cleared, no `step_done`. In HALT it holds HALT.
- Changes to `cmd_div` while not accepting a command have no effect.

## Timing
- Reset values: `state` HALT, `cpu_ce` 0, `step_done` 0, `cycle_count` 0, `pre` 0, `div_q` 1, `steps_left` 0, `cmd_ready` = `!halt_req`.
- Command accepted in cycle t: the new state is visible at t+1. The first `cpu_ce` occurs at cycle t+D (D = effective divide ratio), and every D cycles after that.
- D = 1: `cpu_ce` is high every cycle from t+1.
- The `cycle_count` increment is visible the cycle after the corresponding `cpu_ce`.
- Priority when events coincide:
  - `reset` is highest.
  - `halt_req` next; `cmd_ready` is low, so no command is lost.
  - A CLEAR accept in the same cycle as `cpu_ce`: the count becomes 0 (the increment is discarded).
- A STEP of N at ratio D started at t gives `cpu_ce` at t+D … t+N·D, `state` = HALT and `step_done` = 1 at t+N·D+1.
- `reset` asserted mid-STEP or mid-RUN: the next cycle shows reset values, with no `step_done`.

## Structure
- Package `cpu_clk_pkg`:
  - `cpu_clk_state_t` enum {HALT, RUN, STEP}.
  - `cpu_clk_op_t` enum {OP_RUN, OP_HALT, OP_STEP, OP_CLEAR}.
  - Default width constants.
- One sub-module, `cpu_clk_prescaler`: mod-`div_q` counter with synchronous clear and enable, outputting a terminal-count flag. FSM, step counter and cycle counter stay in `cpu_clk_ctrl`.

## Test plan
- Reset, then RUN with `cmd_div`=4 accepted at t → `cpu_ce` at t+4, t+8, t+12; `cycle_count` = 3 after the third pulse; `state` = 1.
- STEP with `cmd_steps`=3, `cmd_div`=2 from HALT at t → `cpu_ce` at t+2, t+4, t+6; `state` = 0 and `step_done` = 1 at t+7; `cmd_ready` low during t+1..t+6.
- STEP with `cmd_steps`=0, `cmd_div`=0 → exactly one `cpu_ce` at t+1, then `step_done` at t+2.
- RUN `cmd_div`=1; raise `halt_req` in the same cycle as a pending `cpu_ce` → no `cpu_ce` that cycle, `cmd_ready` = 0, `state` = HALT next cycle, count unchanged.
- RUN `cmd_div`=1 with `cycle_count` = 0xFFFF → the next `cpu_ce` wraps the count to 0. CLEAR accepted in a `cpu_ce` cycle → count 0, RUN continues.
- `reset` pulsed during STEP of 10 at step 5 → all outputs at reset values the next cycle, no `step_done`, and no `cpu_ce` until a new command.

Source files
------------

// File: rtl/cpu_clk_pkg.sv
// Shared types and default widths for the CPU clock run/halt/step controller.
package cpu_clk_pkg;

  localparam int unsigned DIV_W_DEF  = 8;
  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned STEP_W_DEF = 8;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } cpu_clk_state_t;

  typedef enum logic [1:0] {
    OP_RUN   = 2'd0,
    OP_HALT  = 2'd1,
    OP_STEP  = 2'd2,
    OP_CLEAR = 2'd3
  } cpu_clk_op_t;

endpackage

// File: rtl/cpu_clk_prescaler.sv
// Mod-div counter with synchronous clear/enable; tc flags the last count (div-1).
module cpu_clk_prescaler #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  output logic             tc
);

  logic [DIV_W-1:0] pre;

  // div is never 0 here: the controller loads max(cmd_div,1).
  assign tc = (pre == div - DIV_W'(1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pre <= '0;
    end else if (enable) begin
      pre <= tc ? '0 : pre + DIV_W'(1);
    end
  end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Run/halt/single-step controller producing the CPU clock enable and a cycle counter.
module cpu_clk_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int unsigned DIV_W  = DIV_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned STEP_W = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DIV_W-1:0]  cmd_div,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              halt_req,
  output logic              cpu_ce,
  output logic [1:0]        state,
  output logic              step_done,
  output logic [CNT_W-1:0]  cycle_count
);

  cpu_clk_state_t    state_q, state_d;
  cpu_clk_op_t       op;
  logic              step_done_d;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  div_eff;
  logic [STEP_W-1:0] steps_left;
  logic [STEP_W-1:0] steps_eff;
  logic              accept;
  logic              running;
  logic              pre_clear;
  logic              tc;

  assign op        = cpu_clk_op_t'(cmd_op);
  assign running   = (state_q != HALT);
  assign cmd_ready = !halt_req && (state_q != STEP);
  assign accept    = cmd_valid && cmd_ready;
  assign div_eff   = (cmd_div == '0) ? DIV_W'(1) : cmd_div;
  assign steps_eff = (cmd_steps == '0) ? STEP_W'(1) : cmd_steps;
  assign cpu_ce    = running && tc && !halt_req;
  assign state     = state_q;

  // CLEAR leaves the prescaler running; every other accepted command restarts it.
  assign pre_clear = !running || halt_req || (accept && (op != OP_CLEAR));

  cpu_clk_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clear  (pre_clear),
    .enable (running),
    .div    (div_q),
    .tc     (tc)
  );

  always_comb begin
    state_d     = state_q;
    step_done_d = 1'b0;
    if (running && halt_req) begin
      state_d = HALT;
    end else if (accept) begin
      case (op)
        OP_RUN:  state_d = RUN;
        OP_STEP: state_d = STEP;
        OP_HALT: state_d = HALT;
        default: state_d = state_q;
      endcase
    end else if ((state_q == STEP) && cpu_ce && (steps_left == STEP_W'(1))) begin
      state_d     = HALT;
      step_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HALT;
      step_done   <= 1'b0;
      div_q       <= DIV_W'(1);
      steps_left  <= '0;
      cycle_count <= '0;
    end else begin
      state_q   <= state_d;
      step_done <= step_done_d;
      if (accept && ((op == OP_RUN) || (op == OP_STEP))) begin
        div_q <= div_eff;
      end
      if (accept && (op == OP_STEP)) begin
        steps_left <= steps_eff;
      end else if (cpu_ce && (state_q == STEP)) begin
        steps_left <= steps_left - STEP_W'(1);
      end
      if (accept && (op == OP_CLEAR)) begin
        cycle_count <= '0;
      end else if (cpu_ce) begin
        cycle_count <= cycle_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl: inputs driven 1ns after posedge, outputs checked at negedge.
module tb_cpu_clk_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_div;
  logic [7:0]  cmd_steps;
  logic        halt_req;
  logic        cpu_ce;
  logic [1:0]  state;
  logic        step_done;
  logic [15:0] cycle_count;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  cpu_clk_ctrl #(
    .DIV_W  (8),
    .CNT_W  (16),
    .STEP_W (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_div     (cmd_div),
    .cmd_steps   (cmd_steps),
    .halt_req    (halt_req),
    .cpu_ce      (cpu_ce),
    .state       (state),
    .step_done   (step_done),
    .cycle_count (cycle_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] div, input logic [7:0] steps);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_div   = div;
    cmd_steps = steps;
    sample();
    check("cmd_ready_on_issue", 32'(cmd_ready), 32'd1);
    advance();
    cmd_valid = 1'b0;
    cmd_div   = 8'd7;
    cmd_steps = 8'd9;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_div = 8'd0;
    cmd_steps = 8'd0; halt_req = 1'b0;
    repeat (2) advance();
    reset = 1'b0;

    sample();
    check("rst_state", 32'(state), 32'd0);
    check("rst_ce", 32'(cpu_ce), 32'd0);
    check("rst_done", 32'(step_done), 32'd0);
    check("rst_count", 32'(cycle_count), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    advance();

    // RUN div 4: ce at t+4, t+8, t+12
    issue(2'd0, 8'd4, 8'd0);
    for (int k = 1; k <= 12; k++) begin
      sample();
      check("run4_ce", 32'(cpu_ce), (k % 4 == 0) ? 32'd1 : 32'd0);
      check("run4_state", 32'(state), 32'd1);
      check("run4_count", 32'(cycle_count), 32'((k - 1) / 4));
      advance();
    end
    sample();
    check("run4_count_final", 32'(cycle_count), 32'd3);
    advance();
    issue(2'd1, 8'd0, 8'd0);
    sample();
    check("halt_state", 32'(state), 32'd0);
    check("halt_ce", 32'(cpu_ce), 32'd0);
    advance();

    // STEP 3 at div 2
    issue(2'd2, 8'd2, 8'd3);
    for (int k = 1; k <= 8; k++) begin
      sample();
      check("step3_ce", 32'(cpu_ce), (k <= 6 && k % 2 == 0) ? 32'd1 : 32'd0);
      check("step3_ready", 32'(cmd_ready), (k <= 6) ? 32'd0 : 32'd1);
      check("step3_state", 32'(state), (k <= 6) ? 32'd2 : 32'd0);
      check("step3_done", 32'(step_done), (k == 7) ? 32'd1 : 32'd0);
      advance();
    end
    sample();
    check("step3_count", 32'(cycle_count), 32'd6);
    advance();

    // STEP 0 at div 0 behaves as STEP 1 at div 1
    issue(2'd2, 8'd0, 8'd0);
    for (int k = 1; k <= 3; k++) begin
      sample();
      check("step0_ce", 32'(cpu_ce), (k == 1) ? 32'd1 : 32'd0);
      check("step0_state", 32'(state), (k == 1) ? 32'd2 : 32'd0);
      check("step0_done", 32'(step_done), (k == 2) ? 32'd1 : 32'd0);
      advance();
    end
    sample();
    check("step0_count", 32'(cycle_count), 32'd7);
    advance();

    // halt_req preempts a pending ce
    issue(2'd0, 8'd1, 8'd0);
    for (int k = 1; k <= 2; k++) begin
      sample();
      check("run1_ce", 32'(cpu_ce), 32'd1);
      advance();
    end
    halt_req = 1'b1;
    sample();
    check("hreq_ce", 32'(cpu_ce), 32'd0);
    check("hreq_ready", 32'(cmd_ready), 32'd0);
    check("hreq_count", 32'(cycle_count), 32'd9);
    advance();
    sample();
    check("hreq_state", 32'(state), 32'd0);
    check("hreq_count_after", 32'(cycle_count), 32'd9);
    check("hreq_ready_halt", 32'(cmd_ready), 32'd0);
    advance();
    halt_req = 1'b0;
    sample();
    check("hreq_drop_ready", 32'(cmd_ready), 32'd1);
    check("hreq_drop_state", 32'(state), 32'd0);
    advance();

    // count wrap at div 1, then CLEAR coinciding with ce
    issue(2'd3, 8'd0, 8'd0);
    sample();
    check("clear_count", 32'(cycle_count), 32'd0);
    advance();
    issue(2'd0, 8'd1, 8'd0);
    repeat (65535) advance();
    sample();
    check("wrap_pre_count", 32'(cycle_count), 32'hFFFF);
    check("wrap_pre_ce", 32'(cpu_ce), 32'd1);
    advance();
    sample();
    check("wrap_count", 32'(cycle_count), 32'd0);
    advance();
    repeat (4) advance();
    sample();
    check("preclear_count", 32'(cycle_count), 32'd5);
    check("preclear_ce", 32'(cpu_ce), 32'd1);
    issue(2'd3, 8'd0, 8'd0);
    sample();
    check("clear_ce_count", 32'(cycle_count), 32'd0);
    check("clear_ce_state", 32'(state), 32'd1);
    check("clear_ce_run", 32'(cpu_ce), 32'd1);
    advance();
    sample();
    check("clear_ce_count_next", 32'(cycle_count), 32'd1);
    advance();
    issue(2'd1, 8'd0, 8'd0);

    // reset mid-STEP after the fifth ce
    issue(2'd2, 8'd2, 8'd10);
    for (int k = 1; k <= 11; k++) begin
      if (k == 11) reset = 1'b1;
      sample();
      check("step10_ce", 32'(cpu_ce), (k % 2 == 0) ? 32'd1 : 32'd0);
      check("step10_state", 32'(state), 32'd2);
      advance();
    end
    reset = 1'b0;
    sample();
    check("rst2_state", 32'(state), 32'd0);
    check("rst2_ce", 32'(cpu_ce), 32'd0);
    check("rst2_done", 32'(step_done), 32'd0);
    check("rst2_count", 32'(cycle_count), 32'd0);
    check("rst2_ready", 32'(cmd_ready), 32'd1);
    advance();
    for (int k = 0; k < 20; k++) begin
      sample();
      check("rst2_idle_ce", 32'(cpu_ce), 32'd0);
      check("rst2_idle_done", 32'(step_done), 32'd0);
      advance();
    end
    sample();
    check("rst2_idle_count", 32'(cycle_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
